// File: rtl/bomb_fuse_controller.sv
// bomb_fuse_controller
// One bomb slot: takes a place request, snaps the bomb to the tile grid,
// counts the fuse in video frames, runs a timed explosion, then frees the slot.
// Optional macro BOMB_BLINK_EN: blinks bomb_exist during the last quarter of the fuse.
//
// Handshake: placeBomb is a level request sampled on every clock. It is accepted
// only in IDLE, and acceptance is signalled by a one-cycle placeAck pulse in the
// same cycle that bomb_exist first reads 1. There is no back-pressure. A request
// held high across the return to IDLE is accepted again on the first IDLE cycle.
//
// Every output comes straight from a flop. Next values are computed in
// always_comb blocks and registered together, so no input reaches an output
// without passing through a register.
module bomb_fuse_controller #(
  parameter int unsigned FUSE_FRAMES    = 180,
  parameter int unsigned EXPLODE_FRAMES = 30,
  parameter int unsigned TILE_BITS      = 5,
  parameter int unsigned MAX_X          = 608,
  parameter int unsigned MAX_Y          = 448
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        placeBomb,
  input  logic        chainHit,
  input  logic [10:0] playerX,
  input  logic [10:0] playerY,
  output logic        bomb_exist,
  output logic        bomb_exploded,
  output logic [10:0] bombTopLeftX,
  output logic [10:0] bombTopLeftY,
  output logic        placeAck,
  output logic        explodeStart,
  output logic [7:0]  fuseLeft,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ARMED     = 2'd1;
  localparam logic [1:0] ST_EXPLODING = 2'd2;

  localparam logic [7:0]  FUSE_LOAD    = 8'(FUSE_FRAMES);
  localparam logic [7:0]  EXPLODE_LOAD = 8'(EXPLODE_FRAMES);
  localparam logic [11:0] HALF_TILE    = 12'(1 << (TILE_BITS - 1));
  localparam logic [11:0] LIMIT_X      = 12'(MAX_X);
  localparam logic [11:0] LIMIT_Y      = 12'(MAX_Y);

  logic [1:0]  state, state_n;
  logic [7:0]  count_n;
  logic [10:0] pos_x_n, pos_y_n;
  logic        ack_n, exs_n, exist_n;

  // Round to the nearest tile (add half a tile, drop the low bits), then clamp.
  // The sum is 12 bits wide so a player near X=2047 cannot wrap around to 0.
  function automatic logic [10:0] snap_to_tile(input logic [10:0] p,
                                               input logic [11:0] lim);
    logic [11:0] sum;
    logic [11:0] grid;
    sum  = {1'b0, p} + HALF_TILE;
    grid = (sum >> TILE_BITS) << TILE_BITS;
    if (grid > lim) grid = lim;
    return grid[10:0];
  endfunction

  // Next-state and next-output logic for the slot FSM.
  always_comb begin
    state_n = state;
    count_n = fuseLeft;
    pos_x_n = bombTopLeftX;
    pos_y_n = bombTopLeftY;
    ack_n   = 1'b0;
    exs_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (placeBomb) begin
          pos_x_n = snap_to_tile(playerX, LIMIT_X);
          pos_y_n = snap_to_tile(playerY, LIMIT_Y);
          count_n = FUSE_LOAD;
          state_n = ST_ARMED;
          ack_n   = 1'b1;
        end
      end
      ST_ARMED: begin
        // Fuse expiry and chainHit share one branch, so they give one pulse.
        if ((startOfFrame && fuseLeft == 8'd1) || chainHit) begin
          state_n = ST_EXPLODING;
          count_n = EXPLODE_LOAD;
          exs_n   = 1'b1;
        end else if (startOfFrame) begin
          count_n = fuseLeft - 8'd1;
        end
      end
      ST_EXPLODING: begin
        if (startOfFrame) begin
          if (fuseLeft == 8'd1) begin
            state_n = ST_IDLE;
            count_n = 8'd0;
          end else begin
            count_n = fuseLeft - 8'd1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        count_n = 8'd0;
      end
    endcase
  end

`ifdef BOMB_BLINK_EN
  localparam logic [7:0] BLINK_LIMIT = 8'(FUSE_FRAMES / 4);

  logic       blink_tog, blink_tog_n;
  logic [2:0] blink_cnt, blink_cnt_n;

  // Blink phase: flips every 8 frames while armed and restarts on every placement.
  always_comb begin
    blink_tog_n = blink_tog;
    blink_cnt_n = blink_cnt;
    if (state != ST_ARMED) begin
      blink_tog_n = 1'b1;
      blink_cnt_n = 3'd0;
    end else if (state_n == ST_ARMED && startOfFrame) begin
      blink_cnt_n = blink_cnt + 3'd1;
      if (blink_cnt == 3'd7) blink_tog_n = ~blink_tog;
    end
  end

  // Visibility: gated by the blink phase only in the last quarter of the fuse.
  always_comb begin
    exist_n = 1'b0;
    if (state_n == ST_ARMED)
      exist_n = (count_n <= BLINK_LIMIT) ? blink_tog_n : 1'b1;
    else if (state_n == ST_EXPLODING)
      exist_n = 1'b1;
  end

  // Blink phase registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_tog <= 1'b1;
      blink_cnt <= 3'd0;
    end else begin
      blink_tog <= blink_tog_n;
      blink_cnt <= blink_cnt_n;
    end
  end
`else
  // Visibility: the bomb is shown whenever the slot is occupied.
  always_comb begin
    exist_n = (state_n != ST_IDLE);
  end
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      fuseLeft      <= 8'd0;
      bombTopLeftX  <= 11'd0;
      bombTopLeftY  <= 11'd0;
      placeAck      <= 1'b0;
      explodeStart  <= 1'b0;
      bomb_exist    <= 1'b0;
      bomb_exploded <= 1'b0;
    end else begin
      state         <= state_n;
      fuseLeft      <= count_n;
      bombTopLeftX  <= pos_x_n;
      bombTopLeftY  <= pos_y_n;
      placeAck      <= ack_n;
      explodeStart  <= exs_n;
      bomb_exist    <= exist_n;
      bomb_exploded <= (state_n == ST_EXPLODING);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_bomb_fuse_controller.sv
// Bench for bomb_fuse_controller. Instance a uses the default timing and is
// tracked by a behavioural model feeding an expected queue. Instance b uses
// FUSE_FRAMES=3 and EXPLODE_FRAMES=2 and is checked against hand-derived values.
module tb_bomb_fuse_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        placeBomb = 1'b0;
  logic        chainHit = 1'b0;
  logic [10:0] playerX = 11'd0;
  logic [10:0] playerY = 11'd0;

  logic        a_exist, a_exploded, a_ack, a_exs;
  logic [10:0] a_x, a_y;
  logic [7:0]  a_fuse;
  logic [1:0]  a_dbg;
  logic        b_exist, b_exploded, b_ack, b_exs;
  logic [10:0] b_x, b_y;
  logic [7:0]  b_fuse;
  logic [1:0]  b_dbg;

  wire [33:0] a_word = {a_exist, a_exploded, a_x, a_y, a_ack, a_exs, a_fuse};
  wire [33:0] b_word = {b_exist, b_exploded, b_x, b_y, b_ack, b_exs, b_fuse};

  bomb_fuse_controller dut_a (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .placeBomb(placeBomb),
    .chainHit(chainHit), .playerX(playerX), .playerY(playerY),
    .bomb_exist(a_exist), .bomb_exploded(a_exploded), .bombTopLeftX(a_x),
    .bombTopLeftY(a_y), .placeAck(a_ack), .explodeStart(a_exs), .fuseLeft(a_fuse),
    .dbg_state(a_dbg)
  );

  bomb_fuse_controller #(.FUSE_FRAMES(3), .EXPLODE_FRAMES(2)) dut_b (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .placeBomb(placeBomb),
    .chainHit(chainHit), .playerX(playerX), .playerY(playerY),
    .bomb_exist(b_exist), .bomb_exploded(b_exploded), .bombTopLeftX(b_x),
    .bombTopLeftY(b_y), .placeAck(b_ack), .explodeStart(b_exs), .fuseLeft(b_fuse),
    .dbg_state(b_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];
  logic [33:0] exp_w;

  // model of instance a: 0=idle 1=armed 2=exploding
  int m_state = 0, m_cnt = 0, m_x = 0, m_y = 0, m_bc = 0;
  bit m_ack = 0, m_exs = 0, m_tog = 1;

  function automatic logic [33:0] model_word();
    bit ex;
`ifdef BOMB_BLINK_EN
    if (m_state == 1) ex = (m_cnt <= 45) ? m_tog : 1'b1;
    else ex = (m_state == 2);
`else
    ex = (m_state != 0);
`endif
    return {ex, (m_state == 2), 11'(m_x), 11'(m_y), m_ack, m_exs, 8'(m_cnt)};
  endfunction

  // ---------------- driver ----------------
  // Drives one clock of inputs, advances the model, queues the expectation.
  task automatic step(input bit r, input bit sof, input bit place, input bit chain,
                      input int px, input int py);
    reset = r; startOfFrame = sof; placeBomb = place; chainHit = chain;
    playerX = 11'(px); playerY = 11'(py);
    m_ack = 0; m_exs = 0;
    if (r) begin
      m_state = 0; m_cnt = 0; m_x = 0; m_y = 0; m_tog = 1; m_bc = 0;
    end else if (m_state == 0) begin
      if (place) begin
        m_x = ((px + 16) / 32) * 32; if (m_x > 608) m_x = 608;
        m_y = ((py + 16) / 32) * 32; if (m_y > 448) m_y = 448;
        m_cnt = 180; m_state = 1; m_ack = 1; m_tog = 1; m_bc = 0;
      end
    end else if (m_state == 1) begin
      if (chain || (sof && m_cnt == 1)) begin
        m_state = 2; m_cnt = 30; m_exs = 1;
      end else if (sof) begin
        m_cnt = m_cnt - 1; m_bc = m_bc + 1;
        if (m_bc == 8) begin m_bc = 0; m_tog = !m_tog; end
      end
    end else begin
      if (sof) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_state = 0;
      end
    end
    exp_q.push_back(model_word());
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    exp_q.delete(0);
    exp_w = exp_q.pop_front(); checks++;
    if (a_word !== exp_w) begin errors++; $display("FAIL reset_a got %h want %h", a_word, exp_w); end
    checks++;
    if (b_word !== 34'd0 || b_dbg !== 2'd0) begin errors++; $display("FAIL reset_b got %h/%0d want 0/0", b_word, b_dbg); end
    step(0, 0, 1, 0, 100, 50);
    exp_w = exp_q.pop_front();
    for (int i = 0; i < 90; i++) begin
      step(0, 1, 0, 0, 0, 0);
      exp_w = exp_q.pop_front(); checks++;
      if (a_word !== exp_w) begin errors++; $display("FAIL fuse_count got %h want %h", a_word, exp_w); end
    end
    checks++;
    if (a_fuse !== 8'd90) begin errors++; $display("FAIL mid_armed got %0d want 90", a_fuse); end
    step(1, 0, 0, 0, 0, 0);
    exp_w = exp_q.pop_front(); checks++;
    if (a_word !== 34'd0 || a_dbg !== 2'd0) begin errors++; $display("FAIL reset_mid_armed got %h want 0", a_word); end
    step(0, 0, 0, 0, 0, 0);
    exp_w = exp_q.pop_front();
    step(0, 0, 1, 0, 200, 200);
    exp_w = exp_q.pop_front(); checks++;
    if (a_ack !== 1'b1 || a_word !== exp_w) begin errors++; $display("FAIL place_after_reset got %h want %h", a_word, exp_w); end
  endtask

  task automatic test_place();
    step(1, 0, 0, 0, 0, 0);
    exp_w = exp_q.pop_front();
    step(0, 0, 1, 0, 100, 50);
    exp_w = exp_q.pop_front(); checks++;
    if (a_x !== 11'd96 || a_y !== 11'd64 || a_ack !== 1'b1 || a_fuse !== 8'd180 || a_exist !== 1'b1)
      begin errors++; $display("FAIL place_snap got x=%0d y=%0d ack=%0d fuse=%0d want 96 64 1 180", a_x, a_y, a_ack, a_fuse); end
    step(0, 0, 0, 0, 0, 0);
    exp_w = exp_q.pop_front(); checks++;
    if (a_ack !== 1'b0 || a_word !== exp_w) begin errors++; $display("FAIL ack_one_cycle got %h want %h", a_word, exp_w); end
  endtask

  task automatic test_clamp();
    step(1, 0, 0, 0, 0, 0);
    exp_w = exp_q.pop_front();
    step(0, 0, 1, 0, 630, 470);
    exp_w = exp_q.pop_front(); checks++;
    if (a_x !== 11'd608 || a_y !== 11'd448) begin errors++; $display("FAIL clamp got %0d,%0d want 608,448", a_x, a_y); end
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0, 0);
      exp_w = exp_q.pop_front();
      step(0, 0, 1, 0, $urandom_range(0, 2047), $urandom_range(0, 2047));
      exp_w = exp_q.pop_front(); checks++;
      if (a_word !== exp_w) begin errors++; $display("FAIL rand_place got %h want %h", a_word, exp_w); end
    end
  endtask

  task automatic test_short_fuse();
    int exploded_frames;
    exploded_frames = 0;
    step(1, 0, 0, 0, 0, 0);
    exp_w = exp_q.pop_front();
    step(0, 0, 1, 0, 0, 0);
    exp_w = exp_q.pop_front(); checks++;
    if (b_ack !== 1'b1 || b_fuse !== 8'd3 || b_exist !== 1'b1) begin errors++; $display("FAIL short_place got ack=%0d fuse=%0d want 1 3", b_ack, b_fuse); end
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 0, 0, 0, 0);
      exp_w = exp_q.pop_front(); checks++;
      if (a_word !== exp_w) begin errors++; $display("FAIL short_a got %h want %h", a_word, exp_w); end
      checks++;
      if (b_exs !== (i == 3) || b_fuse !== ((i == 3) ? 8'd2 : 8'(3 - i)))
        begin errors++; $display("FAIL short_fuse_%0d got exs=%0d fuse=%0d", i, b_exs, b_fuse); end
    end
    for (int i = 0; i < 4; i++) begin
      if (b_exploded) exploded_frames++;
      step(0, 1, 0, 0, 0, 0);
      exp_w = exp_q.pop_front();
    end
    checks++;
    if (exploded_frames !== 2) begin errors++; $display("FAIL explode_len got %0d want 2", exploded_frames); end
    checks++;
    if (b_word !== 34'd0 || b_dbg !== 2'd0) begin errors++; $display("FAIL short_idle got %h want 0", b_word); end
  endtask

  task automatic test_chain();
    int pulses;
    step(1, 0, 0, 0, 0, 0);
    exp_w = exp_q.pop_front();
    step(0, 0, 1, 0, 100, 50);
    exp_w = exp_q.pop_front();
    for (int i = 0; i < 130; i++) begin
      step(0, 1, 0, 0, 0, 0);
      exp_w = exp_q.pop_front();
    end
    checks++;
    if (a_fuse !== 8'd50) begin errors++; $display("FAIL chain_pre got %0d want 50", a_fuse); end
    step(0, 0, 0, 1, 0, 0);
    exp_w = exp_q.pop_front(); checks++;
    if (a_exploded !== 1'b1 || a_exs !== 1'b1 || a_fuse !== 8'd30 || a_dbg !== 2'd2 || a_word !== exp_w)
      begin errors++; $display("FAIL chain_hit got %h want %h", a_word, exp_w); end
    step(0, 0, 0, 1, 0, 0);
    exp_w = exp_q.pop_front(); checks++;
    if (a_exs !== 1'b0 || a_fuse !== 8'd30) begin errors++; $display("FAIL chain_ignored got exs=%0d fuse=%0d want 0 30", a_exs, a_fuse); end
    // coincident chainHit and final fuse frame on instance b
    step(1, 0, 0, 0, 0, 0);
    exp_w = exp_q.pop_front();
    step(0, 0, 1, 0, 0, 0);
    exp_w = exp_q.pop_front();
    step(0, 1, 0, 0, 0, 0); exp_w = exp_q.pop_front();
    step(0, 1, 0, 0, 0, 0); exp_w = exp_q.pop_front();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, (i == 0), 0, 1, 0, 0);
      exp_w = exp_q.pop_front(); checks++;
      if (a_word !== exp_w) begin errors++; $display("FAIL chain_a got %h want %h", a_word, exp_w); end
      if (b_exs) pulses++;
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL chain_coincide got %0d pulses want 1", pulses); end
  endtask

  task automatic test_place_ignored();
    step(1, 0, 0, 0, 0, 0);
    exp_w = exp_q.pop_front();
    step(0, 0, 1, 0, 100, 50);
    exp_w = exp_q.pop_front();
    step(0, 0, 1, 0, 630, 470);
    exp_w = exp_q.pop_front(); checks++;
    if (a_ack !== 1'b0 || a_x !== 11'd96 || a_y !== 11'd64) begin errors++; $display("FAIL ignore_armed got ack=%0d x=%0d y=%0d", a_ack, a_x, a_y); end
    step(0, 0, 1, 1, 630, 470);
    exp_w = exp_q.pop_front();
    step(0, 1, 1, 0, 630, 470);
    exp_w = exp_q.pop_front(); checks++;
    if (a_ack !== 1'b0 || a_x !== 11'd96 || a_exploded !== 1'b1 || a_word !== exp_w)
      begin errors++; $display("FAIL ignore_exploding got %h want %h", a_word, exp_w); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ack_seen, exist_seen;
    step(1, 0, 0, 0, 0, 0);
    exp_w = exp_q.pop_front();
    for (int i = 0; i < 7; i++) begin
      step(0, (i != 0), 1, 0, 0, 0);
      exp_w = exp_q.pop_front(); checks++;
      if (a_word !== exp_w) begin errors++; $display("FAIL b2b_a got %h want %h", a_word, exp_w); end
      ack_seen[i] = b_ack;
      exist_seen[i] = b_exist;
    end
    checks++;
    if (ack_seen !== 7'b1000001 || exist_seen !== 7'b1011111)
      begin errors++; $display("FAIL b2b_replace got ack=%b exist=%b want 1000001 1011111", ack_seen, exist_seen); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_place();
    test_clamp();
    test_short_fuse();
    test_chain();
    test_place_ignored();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
